muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline EX stage. It consumes the two operands read from the register file (ReadData1 into A, ReadData2 into B) for MULT/MULTU/DIV/DIVU. It computes one bit per cycle and holds the results in Hi/Lo for MFHI/MFLO. While an operation runs it asserts Busy so the hazard logic can stall dependent instructions.

## Interface
- WIDTH, 32, operand and result width; the counter is $clog2(WIDTH)+1 bits.
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request to begin the operation selected by Op; sampled only when Busy=0.
- Op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- A  in  WIDTH  multiplicand or dividend (rs).
- B  in  WIDTH  multiplier or divisor (rt).
- HiWrite  in  1  MTHI: load WriteData into Hi.
- LoWrite  in  1  MTLO: load WriteData into Lo.
- WriteData  in  WIDTH  data for MTHI/MTLO.
- Busy  out  1  high while the state is not IDLE.
- Done  out  1  one-cycle pulse when Hi/Lo receive a result.
- Hi  out  WIDTH  HI register (product high half or remainder).
- Lo  out  WIDTH  LO register (product low half or quotient).

## Operation
- States: IDLE, CALC, FIX.
- IDLE with Start=1:
  - Latch |A|, |B| (absolute value only for signed Ops), the result sign bits and Op.
  - Clear the counter and go to CALC.
- CALC: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle. After WIDTH steps go to FIX.
- FIX: apply signs, write Hi/Lo, pulse Done, return to IDLE.
- Sign rules:
  - Product sign is A[31]^B[31].
  - Quotient sign is A[31]^B[31]; remainder sign is A[31].
  - |0x80000000| = 0x80000000 treated as unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Divide by zero (B=0 at Start, DIV or DIVU):
  - Skip CALC and go straight to FIX.
  - FIX writes Hi=A, Lo=0xFFFFFFFF.
- Start while Busy=1 is ignored; the operation in flight is unaffected.
- HiWrite/LoWrite:
  - Honoured only when Busy=0; ignored while Busy=1.
  - If asserted in the same cycle as an accepted Start, the write takes effect at that edge and the later result overwrites it.
- Reset:
  - Hi=0, Lo=0, Busy=0, Done=0, state IDLE, counter 0.
  - Reset during CALC/FIX aborts the operation with no Done and no Hi/Lo update.

## Timing
- Edge E0 samples Start. Busy is high from the cycle after E0 until the cycle after E(WIDTH+1).
- Normal operation:
  - Edges E1..E32 perform the iterations; E32 moves the state to FIX.
  - E33 writes Hi/Lo and sets Done.
  - Hi/Lo are valid and Done=1 in the cycle after E33; Busy=0 in that cycle.
  - Total 33 Busy cycles.
- Divide by zero: E1 writes Hi/Lo; Done is high in the cycle after E1 (1 Busy cycle).
- A Start in the Done cycle is accepted; back-to-back throughput is one operation per 34 cycles.
- Done is registered, never combinational from Start. Hi/Lo change only at the FIX edge or on an MTHI/MTLO edge.
- MTHI/MTLO latency is 1 edge.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are supported as described.
- MULDIV_DIV_EN undefined:
  - The divide datapath is not compiled.
  - DIV/DIVU Start goes straight to FIX and leaves Hi/Lo unchanged.
  - Done is high in the cycle after E1.
  - MULT/MULTU timing is unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State enum (IDLE, CALC, FIX).
  - Iteration count constant.
- Sub-module muldiv_step is natural: a combinational single-iteration step. It takes {rem/hi, quo/lo, divisor/multiplicand, is_div} and returns the next {rem/hi, quo/lo}. It is instantiated once inside muldiv_unit, which owns the FSM, counter, sign fix-up and Hi/Lo registers.

## Test plan
- MULTU, A=B=0xFFFFFFFF, Start at E0:
  - Busy for 33 cycles.
  - Done in the cycle after E33 with Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT:
  - A=0xFFFFFFFD (-3), B=5 gives Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - A=0x80000000, B=0x80000000 gives Hi=0x40000000, Lo=0.
- DIV and DIVU:
  - DIV -7/2 gives Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU 100/7 gives Lo=0x0000000E, Hi=0x00000002.
  - DIV 0x80000000/0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- DIVU 5/0: Done in the cycle after E1 with Hi=5, Lo=0xFFFFFFFF.
- Busy handling and reset:
  - Start MULTU 3*4, then pulse Start with different operands at cycle 5: the second Start is ignored and the result is Lo=12.
  - Repeat the operation and assert Reset at cycle 10: next cycle Busy=0, Hi=Lo=0, and no Done follows.
- MTHI/MTLO:
  - HiWrite with 0x1234 while idle gives Hi=0x1234 after one edge.
  - LoWrite during Busy is ignored; Lo holds the operation result at Done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state type and iteration count.
package muldiv_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = DATA_W;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage interface of the multiply/divide unit: operation request,
// MTHI/MTLO write port and the architectural HI/LO results.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DATA_W);

    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B, HiWrite, LoWrite, WriteData,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, HiWrite, LoWrite, WriteData,
        output Busy, Done, Hi, Lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add on {hi, lo}, lo holding the remaining multiplier bits.
// Divide (only when MULDIV_DIV_EN is defined): restoring subtract-shift,
// hi is the partial remainder and lo shifts the dividend out / quotient in.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    input  logic             is_div,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] mul_sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
`endif

    // Next {hi, lo} for a single multiply or divide iteration
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            // diff[WIDTH] set means the trial subtraction borrowed
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
`else
        if (is_div) begin
            hi_next = hi;
            lo_next = lo;
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per cycle, 33 busy cycles per operation. Build option
// MULDIV_DIV_EN enables the divide datapath; without it DIV/DIVU complete
// after one cycle and leave HI/LO untouched.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = ITER_COUNT
) (
    input  logic     Clk,
    input  logic     Reset,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div_q;
    logic               sign_q;
    logic               bypass_q;
    logic               done_q;
`ifdef MULDIV_DIV_EN
    logic               sign_r_q;
`endif

    logic               op_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic               skip_calc;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand decode: magnitudes, sign bits and the CALC bypass decision
    always_comb begin
        op_div    = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
        op_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
        a_neg     = op_signed & bus.A[WIDTH-1];
        b_neg     = op_signed & bus.B[WIDTH-1];
        a_abs     = a_neg ? -bus.A : bus.A;
        b_abs     = b_neg ? -bus.B : bus.B;
        div_zero  = op_div && (bus.B == '0);
`ifdef MULDIV_DIV_EN
        skip_calc = div_zero;
`else
        skip_calc = op_div;
`endif
        prod_raw  = {work_hi, work_lo};
        prod_fix  = sign_q ? -prod_raw : prod_raw;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .hi      (work_hi),
        .lo      (work_lo),
        .opnd    (opnd),
        .is_div  (is_div_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = skip_calc ? FIX : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, counter, HI/LO and Done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt      <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            bypass_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            sign_r_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.HiWrite) hi_q <= bus.WriteData;
                    if (bus.LoWrite) lo_q <= bus.WriteData;
                    if (bus.Start) begin
                        cnt      <= '0;
                        is_div_q <= op_div;
                        opnd     <= b_abs;
                        bypass_q <= skip_calc;
                        sign_q   <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        sign_r_q <= a_neg;
`endif
                        // Divide by zero preloads the final HI/LO values
                        if (div_zero) begin
                            work_hi <= bus.A;
                            work_lo <= '1;
                        end else begin
                            work_hi <= '0;
                            work_lo <= a_abs;
                        end
                    end
                end
                CALC: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + CNT_W'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (bypass_q) begin
`ifdef MULDIV_DIV_EN
                        hi_q <= work_hi;
                        lo_q <= work_lo;
`endif
                    end else if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                        lo_q <= sign_q   ? -work_lo : work_lo;
                        hi_q <= sign_r_q ? -work_hi : work_hi;
`endif
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of operations with
// hand-computed HI/LO and busy lengths, then sequences for ignored Start,
// MTHI/MTLO while idle and busy, and reset during an operation.
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation, then watch until Done (bounded); optionally inject
    // a Start pulse (1), a LoWrite pulse (2) or Reset (3) at busy cycle inj_cyc.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int inj_kind,
                          output int busy_cnt, output bit got_done, output logic [31:0] lo_mid);
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        busy_cnt  = 0;
        got_done  = 1'b0;
        lo_mid    = 'x;
        for (int i = 0; i < 60; i++) begin
            if (bus.Done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.Busy) busy_cnt++;
            if (i == inj_cyc + 2) lo_mid = bus.Lo;
            if (i == inj_cyc) begin
                case (inj_kind)
                    1: begin bus.Start = 1'b1; bus.A = 32'd100; bus.B = 32'd100; end
                    2: begin bus.LoWrite = 1'b1; bus.WriteData = 32'h0000DEAD; end
                    3: reset = 1'b1;
                    default: ;
                endcase
            end else if (i == inj_cyc + 1) begin
                bus.Start   = 1'b0;
                bus.LoWrite = 1'b0;
                reset       = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        vecs [13];
        logic [31:0] prev_hi, prev_lo, exp_hi, exp_lo, lm;
        int          exp_busy, bc;
        bit          gd;

        bus.Start = 1'b0; bus.Op = 2'd0; bus.A = '0; bus.B = '0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WriteData = '0;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1};
        vecs[7]  = '{OP_MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 33};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{OP_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
        vecs[10] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1};
        vecs[11] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 33};
        vecs[12] = '{OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 33};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, bus.Busy}, 32'd0);
        check("reset done", {31'b0, bus.Done}, 32'd0);
        check("reset hi",   bus.Hi, 32'd0);
        check("reset lo",   bus.Lo, 32'd0);
        reset = 1'b0;

        prev_hi = '0;
        prev_lo = '0;
        for (int v = 0; v < 13; v++) begin
            exp_hi   = vecs[v].hi;
            exp_lo   = vecs[v].lo;
            exp_busy = vecs[v].busy;
            if (vecs[v].op[1] && !DIV_EN) begin
                exp_hi   = prev_hi;
                exp_lo   = prev_lo;
                exp_busy = 1;
            end
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, -1, 0, bc, gd, lm);
            check($sformatf("v%0d done", v),      {31'b0, gd}, 32'd1);
            check($sformatf("v%0d busy_cnt", v),  32'(bc), 32'(exp_busy));
            check($sformatf("v%0d busy_low", v),  {31'b0, bus.Busy}, 32'd0);
            check($sformatf("v%0d hi", v),        bus.Hi, exp_hi);
            check($sformatf("v%0d lo", v),        bus.Lo, exp_lo);
            prev_hi = exp_hi;
            prev_lo = exp_lo;
        end

        // Start pulse while busy must not disturb the running MULTU 3*4
        run_op(OP_MULTU, 32'd3, 32'd4, 5, 1, bc, gd, lm);
        check("ignored_start done",     {31'b0, gd}, 32'd1);
        check("ignored_start busy_cnt", 32'(bc), 32'd33);
        check("ignored_start hi",       bus.Hi, 32'd0);
        check("ignored_start lo",       bus.Lo, 32'd12);

        // LoWrite while busy is ignored; Lo keeps 12 until the result lands
        run_op(OP_MULTU, 32'd6, 32'd7, 5, 2, bc, gd, lm);
        check("busy_mtlo lo_mid",   lm, 32'd12);
        check("busy_mtlo done",     {31'b0, gd}, 32'd1);
        check("busy_mtlo busy_cnt", 32'(bc), 32'd33);
        check("busy_mtlo lo",       bus.Lo, 32'd42);

        // MTHI / MTLO while idle, one-edge latency
        bus.HiWrite = 1'b1; bus.WriteData = 32'h00001234;
        @(posedge clk); #1;
        bus.HiWrite = 1'b0;
        check("mthi hi", bus.Hi, 32'h00001234);
        check("mthi lo", bus.Lo, 32'd42);
        bus.LoWrite = 1'b1; bus.WriteData = 32'h00005678;
        @(posedge clk); #1;
        bus.LoWrite = 1'b0;
        check("mtlo lo", bus.Lo, 32'h00005678);

        // Reset at busy cycle 10 aborts with no Done and clears HI/LO
        run_op(OP_MULTU, 32'd3, 32'd4, 10, 3, bc, gd, lm);
        check("abort busy_cnt", 32'(bc), 32'd11);
        check("abort no_done",  {31'b0, gd}, 32'd0);
        check("abort busy",     {31'b0, bus.Busy}, 32'd0);
        check("abort hi",       bus.Hi, 32'd0);
        check("abort lo",       bus.Lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
